// File: rtl/textmode_pkg.sv
// textmode_pkg: shared constants and types for the text-mode write path.
//
// Contents:
//   TM_ADDR_W / TM_ROW_W / TM_COL_W / TM_DATA_W : RAM write address field widths
//   tm_state_t : SPI framing state (scroll, address high, address low, data)
//   tm_wr_t    : one queued RAM write {addr, data}
//   fill_rows  : maps the 8-bit fill row count to a row total (0 means 128)
package textmode_pkg;

  localparam int TM_ADDR_W = 15;
  localparam int TM_ROW_W  = 7;
  localparam int TM_COL_W  = 7;
  localparam int TM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_SCROLL = 2'd0,
    ST_HI     = 2'd1,
    ST_LO     = 2'd2,
    ST_DATA   = 2'd3
  } tm_state_t;

  typedef struct packed {
    logic [TM_ADDR_W-1:0] addr;
    logic [TM_DATA_W-1:0] data;
  } tm_wr_t;

  // A count of zero requests a full-screen fill of 128 rows.
  function automatic logic [7:0] fill_rows(input logic [7:0] count);
    return (count == 8'd0) ? 8'd128 : count;
  endfunction

endpackage

// File: rtl/tm_wr_fifo.sv
// tm_wr_fifo: synchronous first-word-fall-through FIFO of tm_wr_t entries.
//
// Parameters:
//   DEPTH : number of entries, power of two, >= 2
// Ports:
//   clk, rst   : clock and synchronous active-high reset (empties the queue)
//   push       : write push_data this cycle (ignored when full unless popping)
//   push_data  : entry to enqueue
//   pop        : remove the head entry this cycle (ignored when empty)
//   head       : current head entry, valid whenever empty is low
//   full/empty : occupancy flags
//
// The head is read combinationally so that an entry pushed on one edge can be
// issued on the very next edge; the storage is a small distributed array.
module tm_wr_fifo
  import textmode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  tm_wr_t push_data,
  input  logic   pop,
  output tm_wr_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  tm_wr_t         mem [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic           do_push;
  logic           do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign do_push = push && (!full || do_pop);

  assign head = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

  // Storage has no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/textmode_wr_sched.sv
// textmode_wr_sched: owner of the text-mode RAM write port and Y-scroll register.
//
// Decodes the framed SPI byte stream (scroll, address high, address low, then
// auto-incrementing data) into queued RAM writes, and shares the write port
// with an optional row fill engine. Queued SPI writes always win the port.
//
// Build option: define TEXTMODE_FILL_EN to include the fill engine. Without it
// fill_busy/fill_done are tied low and the fill_* inputs are ignored.
//
// Parameters:
//   FIFO_DEPTH : SPI write-queue entries (power of two, >= 2)
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   spi_sel         : synchronised SSEL, high = deselected (frame restart)
//   spi_we/spi_byte : one-cycle received-byte strobe and its data
//   fill_start      : one-cycle fill request (ignored while fill_busy)
//   fill_row/count  : first row and row count (0 = 128) of the fill
//   fill_char/attr  : bytes written to every character / attribute cell
//   fill_busy/done  : fill in progress / one-cycle completion pulse
//   spi_ovf         : sticky queue-overflow flag
//   scroll          : Y scroll register
//   ram_write/addr/d: registered RAM write port, addr = {row, col, sel}
module textmode_wr_sched
  import textmode_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_sel,
  input  logic                 spi_we,
  input  logic [7:0]           spi_byte,
  input  logic                 fill_start,
  input  logic [6:0]           fill_row,
  input  logic [7:0]           fill_count,
  input  logic [7:0]           fill_char,
  input  logic [7:0]           fill_attr,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic                 spi_ovf,
  output logic [6:0]           scroll,
  output logic                 ram_write,
  output logic [TM_ADDR_W-1:0] ram_addr,
  output logic [7:0]           ram_d
);

  // ---------------------------------------------------------------------------
  // SPI framing
  // ---------------------------------------------------------------------------
  tm_state_t            state_reg;
  logic [TM_ADDR_W-1:0] addr_reg;

  logic   push;
  logic   pop;
  logic   q_full;
  logic   q_empty;
  tm_wr_t push_entry;
  tm_wr_t head;

  // Deselect in the same cycle as a strobe discards the byte.
  assign push       = !spi_sel && spi_we && (state_reg == ST_DATA);
  assign push_entry = '{addr: addr_reg, data: spi_byte};

  // The queue drains one entry per cycle whenever it holds anything.
  assign pop = !q_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_SCROLL;
      addr_reg  <= '0;
      scroll    <= '0;
      spi_ovf   <= 1'b0;
    end else begin
      if (push && q_full && !pop) begin
        spi_ovf <= 1'b1;
      end
      if (spi_sel) begin
        state_reg <= ST_SCROLL;
      end else if (spi_we) begin
        case (state_reg)
          ST_SCROLL: begin
            scroll    <= spi_byte[6:0];
            state_reg <= ST_HI;
          end
          ST_HI: begin
            addr_reg[14:8] <= spi_byte[6:0];
            state_reg      <= ST_LO;
          end
          ST_LO: begin
            addr_reg[7:0] <= spi_byte;
            state_reg     <= ST_DATA;
          end
          ST_DATA: begin
            // 15-bit increment wraps 0x7FFF to 0x0000 naturally.
            addr_reg <= addr_reg + TM_ADDR_W'(1);
          end
          default: state_reg <= ST_SCROLL;
        endcase
      end
    end
  end

  tm_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // ---------------------------------------------------------------------------
  // Fill engine
  // ---------------------------------------------------------------------------
  logic                 fill_grant;
  logic [TM_ADDR_W-1:0] fill_addr;
  logic [7:0]           fill_data;

`ifdef TEXTMODE_FILL_EN
  logic [TM_ROW_W-1:0] fill_row_reg;
  // Cell index within a row: {col[6:0], sel}, so one row is 256 writes.
  logic [7:0]          fill_cell_reg;
  logic [7:0]          rows_left_reg;
  logic [7:0]          fill_char_reg;
  logic [7:0]          fill_attr_reg;
  logic                fill_last;

  // The cursor only moves when the fill actually owns the port.
  assign fill_grant = q_empty && fill_busy;
  assign fill_last  = (rows_left_reg == 8'd1) && (fill_cell_reg == 8'hFF);
  assign fill_addr  = {fill_row_reg, fill_cell_reg};
  assign fill_data  = fill_cell_reg[0] ? fill_attr_reg : fill_char_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_busy     <= 1'b0;
      fill_done     <= 1'b0;
      fill_row_reg  <= '0;
      fill_cell_reg <= '0;
      rows_left_reg <= '0;
      fill_char_reg <= '0;
      fill_attr_reg <= '0;
    end else begin
      fill_done <= 1'b0;
      if (fill_busy) begin
        if (fill_grant) begin
          if (fill_last) begin
            fill_busy <= 1'b0;
            fill_done <= 1'b1;
          end else begin
            fill_cell_reg <= fill_cell_reg + 8'd1;
            if (fill_cell_reg == 8'hFF) begin
              // Row index wraps mod 128 by its width.
              fill_row_reg  <= fill_row_reg + 7'd1;
              rows_left_reg <= rows_left_reg - 8'd1;
            end
          end
        end
      end else if (fill_start) begin
        fill_busy     <= 1'b1;
        fill_row_reg  <= fill_row;
        fill_cell_reg <= 8'd0;
        rows_left_reg <= fill_rows(fill_count);
        fill_char_reg <= fill_char;
        fill_attr_reg <= fill_attr;
      end
    end
  end
`else
  logic unused_fill;

  assign fill_grant  = 1'b0;
  assign fill_addr   = '0;
  assign fill_data   = '0;
  assign fill_busy   = 1'b0;
  assign fill_done   = 1'b0;
  assign unused_fill = ^{fill_start, fill_row, fill_count, fill_char, fill_attr};
`endif

  // ---------------------------------------------------------------------------
  // Write-port arbitration: queued SPI first, then fill, else idle (hold bus)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_d     <= '0;
    end else if (pop) begin
      ram_write <= 1'b1;
      ram_addr  <= head.addr;
      ram_d     <= head.data;
    end else if (fill_grant) begin
      ram_write <= 1'b1;
      ram_addr  <= fill_addr;
      ram_d     <= fill_data;
    end else begin
      ram_write <= 1'b0;
    end
  end

endmodule
